// File: rtl/exe_mul_sequencer_pkg.sv
// Shared definitions for the EXE-stage multi-cycle multiply sequencer:
// command codes, FSM state encodings and counter width.
package exe_mul_sequencer_pkg;

    localparam int REGISTER_LEN        = 32;
    localparam int EXECUTE_COMMAND_LEN = 4;
    localparam int MUL_CNT_LEN         = 5;

    localparam logic [EXECUTE_COMMAND_LEN-1:0] EXE_MUL_CMD = 4'b1010;
    localparam logic [EXECUTE_COMMAND_LEN-1:0] EXE_MLA_CMD = 4'b1011;

    typedef enum logic [1:0] {
        MUL_IDLE   = 2'b00,
        MUL_RUN    = 2'b01,
        MUL_FINISH = 2'b10
    } mul_state_e;

endpackage

// File: rtl/exe_mul_sequencer_dp.sv
// Radix-2 shift-add datapath (mcand/mplier/acc) driven by load/step strobes.
// With EXE_MUL_EARLY_TERM_EN defined it also reports when the multiplier is exhausted.
module exe_mul_sequencer_dp
    import exe_mul_sequencer_pkg::*;
#(
    parameter int WIDTH = REGISTER_LEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [WIDTH-1:0] acc_init,
`ifdef EXE_MUL_EARLY_TERM_EN
    output logic             mplier_last,
`endif
    output logic [WIDTH-1:0] acc_nxt
);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;

    // acc_nxt is what acc becomes after this step; the FSM captures it on the final step
    assign acc_nxt = mplier[0] ? acc + mcand : acc;

`ifdef EXE_MUL_EARLY_TERM_EN
    assign mplier_last = (mplier[WIDTH-1:1] == '0);
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (load) begin
            mcand  <= operand_a;
            mplier <= operand_b;
            acc    <= acc_init;
        end else if (step) begin
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            acc    <= acc_nxt;
        end
    end

endmodule

// File: rtl/exe_mul_sequencer.sv
// MUL/MLA sequencer: freezes the front end, iterates the shift-add datapath and
// pulses done with result/flags. EXE_MUL_EARLY_TERM_EN enables early exit.
module exe_mul_sequencer
    import exe_mul_sequencer_pkg::*;
#(
    parameter int WIDTH = REGISTER_LEN,
    parameter int CNT_W = MUL_CNT_LEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             accumulate,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [WIDTH-1:0] acc_in,
    input  logic             flush,
    input  logic [3:0]       status_in,
    output logic             busy,
    output logic             freeze,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       status_out
);

    mul_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       cv_q;
    logic             load, step, capture, freeze_c, last_iter;
    logic [WIDTH-1:0] acc_nxt;
    logic             unused_nz;

    // N and Z come from the result itself; only C and V are carried over
    assign unused_nz = ^status_in[3:2];

    function automatic logic [3:0] mul_flags(input logic [WIDTH-1:0] r, input logic [1:0] cv);
        return {r[WIDTH-1], (r == '0), cv};
    endfunction

`ifdef EXE_MUL_EARLY_TERM_EN
    logic mplier_last;
    assign last_iter = (cnt == CNT_W'(WIDTH-1)) || mplier_last;
`else
    assign last_iter = (cnt == CNT_W'(WIDTH-1));
`endif

    exe_mul_sequencer_dp #(.WIDTH(WIDTH)) u_dp (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .step       (step),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .acc_init   (accumulate ? acc_in : '0),
`ifdef EXE_MUL_EARLY_TERM_EN
        .mplier_last(mplier_last),
`endif
        .acc_nxt    (acc_nxt)
    );

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        capture   = 1'b0;
        freeze_c  = 1'b0;
        case (state)
            MUL_IDLE: begin
                if (start && !flush) begin
                    load      = 1'b1;
                    freeze_c  = 1'b1;
                    state_nxt = MUL_RUN;
                end
            end
            MUL_RUN: begin
                step     = 1'b1;
                freeze_c = 1'b1;
                if (flush) begin
                    state_nxt = MUL_IDLE;
                end else if (last_iter) begin
                    capture   = 1'b1;
                    state_nxt = MUL_FINISH;
                end
            end
            MUL_FINISH: state_nxt = MUL_IDLE;
            default:    state_nxt = MUL_IDLE;
        endcase
    end

    assign freeze = freeze_c & rst;
    assign busy   = (state != MUL_IDLE);
    assign done   = (state == MUL_FINISH);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= MUL_IDLE;
            cnt        <= '0;
            cv_q       <= '0;
            result     <= '0;
            status_out <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                cnt  <= '0;
                cv_q <= status_in[1:0];
            end else if (step) begin
                cnt <= cnt + 1'b1;
            end
            if (capture) begin
                result     <= acc_nxt;
                status_out <= mul_flags(acc_nxt, cv_q);
            end
        end
    end

endmodule

// File: tb/tb_exe_mul_sequencer.sv
// Directed self-checking bench for exe_mul_sequencer (both EXE_MUL_EARLY_TERM_EN builds).
module tb_exe_mul_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, accumulate, flush;
    logic [31:0] operand_a, operand_b, acc_in;
    logic [3:0]  status_in;
    logic        busy, freeze, done;
    logic [31:0] result;
    logic [3:0]  status_out;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    exe_mul_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .accumulate(accumulate),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .acc_in    (acc_in),
        .flush     (flush),
        .status_in (status_in),
        .busy      (busy),
        .freeze    (freeze),
        .done      (done),
        .result    (result),
        .status_out(status_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic int lat_of(input logic [31:0] b);
`ifdef EXE_MUL_EARLY_TERM_EN
        int m;
        m = 0;
        for (int i = 0; i < 32; i++) if (b[i]) m = i;
        return 2 + m;
`else
        return (b == b) ? 33 : 0;
`endif
    endfunction

    // Issue one op at cycle 0, track freeze each cycle, and check the done cycle.
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] acc, input logic mla, input logic [3:0] st,
                         input logic [31:0] exp_res, input logic [3:0] exp_st,
                         input int restart_at);
        int  cyc;
        bit  seen;
        bit  fr_ok;
        @(negedge clk);
        operand_a = a; operand_b = b; acc_in = acc; accumulate = mla;
        status_in = st; start = 1'b1;
        #1 check({tag, "_freeze_c0"}, freeze, 1);
        cyc = 0; seen = 0; fr_ok = 1;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            start = (cyc == restart_at);
            if (done) seen = 1;
            else if (!freeze) fr_ok = 0;
        end
        start = 1'b0;
        if (!seen) begin
            check({tag, "_done_timeout"}, 0, 1);
        end else begin
            check({tag, "_latency"}, cyc, lat_of(b));
            check({tag, "_freeze_held"}, fr_ok, 1);
            check({tag, "_freeze_fin"}, freeze, 0);
            check({tag, "_busy_fin"}, busy, 1);
            check({tag, "_result"}, result, exp_res);
            check({tag, "_status"}, status_out, exp_st);
            @(negedge clk);
            check({tag, "_idle_after"}, {busy, done}, 0);
            check({tag, "_result_hold"}, result, exp_res);
        end
    endtask

    initial begin
        int dcount;
        rst = 1'b0; start = 1'b1; accumulate = 1'b0; flush = 1'b0;
        operand_a = 32'd1; operand_b = 32'd1; acc_in = '0; status_in = 4'hF;

        // Reset state; start held high must not freeze while in reset
        repeat (2) @(negedge clk);
        check("rst_freeze", freeze, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_status", status_out, 0);
        start = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        do_op("mul_7x6", 32'd7, 32'd6, 32'd0, 1'b0, 4'b0011, 32'h0000002A, 4'b0011, -1);
        do_op("mla_wrap", 32'hFFFFFFFF, 32'd2, 32'd3, 1'b1, 4'b0000, 32'h00000001, 4'b0000, -1);
        do_op("mul_neg", 32'h80000000, 32'd1, 32'd0, 1'b0, 4'b0010, 32'h80000000, 4'b1010, -1);
`ifdef EXE_MUL_EARLY_TERM_EN
        do_op("mul_zero", 32'h12345678, 32'd0, 32'd0, 1'b0, 4'b0000, 32'h0, 4'b0100, -1);
`else
        do_op("mul_zero", 32'h12345678, 32'd0, 32'd0, 1'b0, 4'b0000, 32'h0, 4'b0100, 5);
`endif
        do_op("mla_acc", 32'd3, 32'h10, 32'd100, 1'b1, 4'b0001, 32'h00000094, 4'b0001, -1);
        do_op("mul_b5", 32'h11111111, 32'd5, 32'd0, 1'b0, 4'b0000, 32'h55555555, 4'b0000, -1);
        do_op("mul_bmsb", 32'd3, 32'h80000000, 32'd0, 1'b0, 4'b0000, 32'h80000000, 4'b1000, -1);

        // Flush at cycle 10 of a run
        @(negedge clk);
        operand_a = 32'd9; operand_b = 32'hFFFF0000; accumulate = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("flush_c10_busy", {busy, freeze}, 2'b11);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_c11_busy", busy, 0);
        check("flush_c11_freeze", freeze, 0);
        dcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("flush_no_done", dcount, 0);
        check("flush_result_kept", result, 32'h80000000);

        // start & flush together in IDLE is dropped
        start = 1'b1; flush = 1'b1;
        #1 check("idle_flush_freeze", freeze, 0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("idle_flush_busy", busy, 0);

        // Reset at cycle 15 of a run
        @(negedge clk);
        operand_a = 32'd5; operand_b = 32'hFFFFFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        check("rst_mid_busy_c15", busy, 1);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_freeze", freeze, 0);
        check("rst_mid_result", result, 0);
        check("rst_mid_status", status_out, 0);
        rst = 1'b1;
        do_op("after_rst", 32'h1234, 32'h10, 32'd0, 1'b0, 4'b0000, 32'h00012340, 4'b0000, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
